// File: rtl/music_sequencer.sv
`timescale 1ns/1ps
// music_sequencer: play/pause, next/prev song select, beat generation and song-ROM stepping.
// Latency: play_button to first new_note is 3 cycles; 2-cycle FETCH/LOAD gap between notes.
// Optional feature macro SEQ_REPEAT_EN: when defined, repeat_switch restarts the song at its end.
module music_sequencer #(
  parameter int NUM_SONGS   = 4,
  parameter int SONG_ADDR_W = 5,
  parameter int NOTE_W      = 6,
  parameter int DUR_W       = 6,
  parameter int BEAT_COUNT  = 1000,
  parameter int BEAT_CNT_W  = 10,
  localparam int SONG_W     = $clog2(NUM_SONGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play_button,
  input  logic                          next_button,
  input  logic                          prev_button,
  input  logic                          ff_switch,
  input  logic                          rw_switch,
  input  logic                          repeat_switch,
  input  logic                          generate_next_sample,
  output logic [SONG_W+SONG_ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]       rom_data,
  output logic [NOTE_W-1:0]             note,
  output logic                          new_note,
  output logic                          note_active,
  output logic                          beat,
  output logic                          play,
  output logic [SONG_W-1:0]             current_song,
  output logic                          song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SOUND,
    S_PAUSE,
    S_END
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_play, w_play_nxt;
  logic [SONG_W-1:0]       r_song, w_song_nxt, w_song_inc, w_song_dec;
  logic [SONG_ADDR_W-1:0]  r_idx, w_idx_nxt;
  logic [NOTE_W-1:0]       r_note, w_note_nxt;
  logic [DUR_W-1:0]        r_rem, w_rem_nxt;
  logic [BEAT_CNT_W-1:0]   r_cnt, w_cnt_nxt, w_term;
  logic                    r_beat, w_beat_nxt;
  logic                    r_new_note, w_new_note_nxt;
  logic                    r_done, w_done_nxt;
  logic [NOTE_W-1:0]       w_rom_note;
  logic [DUR_W-1:0]        w_rom_dur;
  logic                    w_repeat;

  assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur  = rom_data[DUR_W-1:0];

  // Song index wraps in both directions over NUM_SONGS entries.
  assign w_song_inc = (r_song == SONG_W'(NUM_SONGS - 1)) ? '0 : r_song + 1'b1;
  assign w_song_dec = (r_song == '0) ? SONG_W'(NUM_SONGS - 1) : r_song - 1'b1;

  // Fast-forward halves the beat period; the compare uses >= so a switch to a
  // shorter period with the counter already past it wraps on the next strobe.
  assign w_term = ff_switch ? BEAT_CNT_W'((BEAT_COUNT >> 1) - 1) : BEAT_CNT_W'(BEAT_COUNT - 1);

`ifdef SEQ_REPEAT_EN
  assign w_repeat = repeat_switch;
`else
  logic w_unused_repeat;
  assign w_unused_repeat = repeat_switch;
  assign w_repeat        = 1'b0;
`endif

  // Next-state and next-value logic; song buttons override everything at the end.
  always_comb begin
    w_state_nxt    = r_state;
    w_play_nxt     = r_play;
    w_song_nxt     = r_song;
    w_idx_nxt      = r_idx;
    w_note_nxt     = r_note;
    w_rem_nxt      = r_rem;
    w_cnt_nxt      = r_cnt;
    w_beat_nxt     = 1'b0;
    w_new_note_nxt = 1'b0;
    w_done_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (play_button) begin
          w_state_nxt = S_FETCH;
          w_play_nxt  = 1'b1;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_rom_dur == '0) begin
          w_state_nxt = S_END;
          w_done_nxt  = 1'b1;
        end else begin
          w_note_nxt     = w_rom_note;
          w_rem_nxt      = w_rom_dur;
          w_cnt_nxt      = '0;
          w_new_note_nxt = 1'b1;
          w_state_nxt    = S_SOUND;
        end
      end
      S_SOUND: begin
        if (play_button) begin
          w_state_nxt = S_PAUSE;
          w_play_nxt  = 1'b0;
        end else if (generate_next_sample) begin
          if (r_cnt >= w_term) begin
            w_cnt_nxt  = '0;
            w_beat_nxt = 1'b1;
            w_rem_nxt  = r_rem - 1'b1;
            if (r_rem == DUR_W'(1)) begin
              if (rw_switch) begin
                if (r_idx == '0) begin
                  w_state_nxt = S_END;
                  w_done_nxt  = 1'b1;
                end else begin
                  w_idx_nxt   = r_idx - 1'b1;
                  w_state_nxt = S_FETCH;
                end
              end else begin
                if (&r_idx) begin
                  w_state_nxt = S_END;
                  w_done_nxt  = 1'b1;
                end else begin
                  w_idx_nxt   = r_idx + 1'b1;
                  w_state_nxt = S_FETCH;
                end
              end
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (play_button) begin
          w_state_nxt = S_SOUND;
          w_play_nxt  = 1'b1;
        end
      end
      S_END: begin
        w_idx_nxt = '0;
        if (w_repeat) begin
          w_state_nxt = S_FETCH;
        end else begin
          w_play_nxt  = 1'b0;
          w_song_nxt  = w_song_inc;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (next_button || prev_button) begin
      w_state_nxt    = S_IDLE;
      w_play_nxt     = 1'b0;
      w_idx_nxt      = '0;
      w_cnt_nxt      = '0;
      w_beat_nxt     = 1'b0;
      w_new_note_nxt = 1'b0;
      w_done_nxt     = 1'b0;
      w_song_nxt     = next_button ? w_song_inc : w_song_dec;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: song/index, note, counters and one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_play     <= 1'b0;
      r_song     <= '0;
      r_idx      <= '0;
      r_note     <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_beat     <= 1'b0;
      r_new_note <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_play     <= w_play_nxt;
      r_song     <= w_song_nxt;
      r_idx      <= w_idx_nxt;
      r_note     <= w_note_nxt;
      r_rem      <= w_rem_nxt;
      r_cnt      <= w_cnt_nxt;
      r_beat     <= w_beat_nxt;
      r_new_note <= w_new_note_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign rom_addr     = {r_song, r_idx};
  assign note         = r_note;
  assign new_note     = r_new_note;
  assign note_active  = (r_state == S_SOUND);
  assign beat         = r_beat;
  assign play         = r_play;
  assign current_song = r_song;
  assign song_done    = r_done;

endmodule

// File: tb/tb_music_sequencer.sv
`timescale 1ns/1ps
// Testbench for music_sequencer: directed scenarios plus randomized songs checked
// against a song-level model (note list and strobe counts derived from ROM contents).
module tb_music_sequencer;
  localparam int NS = 4, SAW = 5, NW = 6, DW = 6, BC = 4, BCW = 10, SW = 2;
  localparam int N_ENT = 1 << SAW;

  logic clk = 1'b0;
  logic reset, play_button, next_button, prev_button;
  logic ff_switch, rw_switch, repeat_switch, gen;
  logic [SW+SAW-1:0] rom_addr;
  logic [NW+DW-1:0]  rom_data;
  logic [NW-1:0]     note;
  logic new_note, note_active, beat, play, song_done;
  logic [SW-1:0]     current_song;

  logic [NW+DW-1:0] rom_mem [NS*N_ENT];
  int n_cmp = 0, n_fail = 0;
  int exp_song = 0;
  int exp_note[$], exp_dur[$];
  bit strobe_en = 1'b0;

  music_sequencer #(
    .NUM_SONGS(NS), .SONG_ADDR_W(SAW), .NOTE_W(NW), .DUR_W(DW),
    .BEAT_COUNT(BC), .BEAT_CNT_W(BCW)
  ) dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .ff_switch(ff_switch), .rw_switch(rw_switch),
    .repeat_switch(repeat_switch), .generate_next_sample(gen), .rom_addr(rom_addr),
    .rom_data(rom_data), .note(note), .new_note(new_note), .note_active(note_active),
    .beat(beat), .play(play), .current_song(current_song), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Sample strobe every third cycle, driven shortly after the rising edge.
  initial begin
    int ph;
    ph  = 0;
    gen = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      gen = strobe_en && (ph == 0);
      ph  = (ph == 2) ? 0 : ph + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ent(input int s, input int i, input int n, input int d);
    rom_mem[s*N_ENT+i] = {NW'(n), DW'(d)};
  endtask

  // Reference: a song plays entries from index 0 upward until a zero duration
  // or the last index; each note lasts duration x beat-period strobes.
  function automatic void build_model(input int s);
    logic [NW+DW-1:0] e;
    exp_note.delete();
    exp_dur.delete();
    for (int i = 0; i < N_ENT; i++) begin
      e = rom_mem[s*N_ENT+i];
      if (e[DW-1:0] == 0) break;
      exp_note.push_back(int'(e[NW+DW-1:DW]));
      exp_dur.push_back(int'(e[DW-1:0]));
    end
  endfunction

  // 0: play, 1: next, 2: prev, 3: next+prev. Returns at the falling edge of the
  // cycle after the button cycle.
  task automatic press(input int which);
    @(posedge clk);
    #2;
    play_button = (which == 0);
    next_button = (which == 1) || (which == 3);
    prev_button = (which == 2) || (which == 3);
    @(posedge clk);
    #2;
    play_button = 1'b0;
    next_button = 1'b0;
    prev_button = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_new_note(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (new_note) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (song_done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // Counts strobes seen while sounding and beat pulses, from the current sample
  // until note_active falls (or stop_after strobes when nonzero).
  task automatic run_note(input int stop_after, output int strobes, output int beats, output bit ok);
    strobes = 0;
    beats   = 0;
    ok      = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (note_active && gen) strobes++;
      if (beat) beats++;
      if (!note_active) begin ok = 1'b1; break; end
      if (stop_after != 0 && strobes == stop_after) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic play_song_check(input string tag, input bit ff);
    int st, bt;
    bit ok;
    build_model(exp_song);
    ff_switch = ff;
    press(0);
    foreach (exp_note[k]) begin
      wait_new_note(ok);
      check({tag, "_new_note"}, 32'(ok), 1);
      if (!ok) return;
      check({tag, "_note"}, 32'(note), 32'(exp_note[k]));
      run_note(0, st, bt, ok);
      check({tag, "_strobes"}, 32'(st), 32'(exp_dur[k] * (ff ? BC/2 : BC)));
      check({tag, "_beats"}, 32'(bt), 32'(exp_dur[k]));
    end
    wait_done(ok);
    check({tag, "_song_done"}, 32'(ok), 1);
    @(negedge clk);
    exp_song = (exp_song + 1) % NS;
    check({tag, "_play_end"}, 32'(play), 0);
    check({tag, "_song_end"}, 32'(current_song), 32'(exp_song));
    ff_switch = 1'b0;
  endtask

  task automatic load_basic(input int s);
    set_ent(s, 0, 10, 2);
    set_ent(s, 1, 20, 1);
    set_ent(s, 2, 7, 0);
  endtask

  task automatic load_random(input int s, input bit full);
    int n;
    n = $urandom_range(1, 4);
    for (int i = 0; i < N_ENT; i++) begin
      set_ent(s, i, $urandom_range(1, 63), (full || i < n) ? $urandom_range(1, 3) : 0);
    end
  endtask

  initial begin
    int st, bt, viol;
    bit ok;
    reset = 1'b0; play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0;
    ff_switch = 1'b0; rw_switch = 1'b0; repeat_switch = 1'b0;
    for (int i = 0; i < NS*N_ENT; i++) rom_mem[i] = '0;
    for (int s = 0; s < NS; s++) load_basic(s);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_play", 32'(play), 0);
    check("rst_song", 32'(current_song), 0);
    check("rst_note", 32'(note), 0);
    check("rst_new_note", 32'(new_note), 0);
    check("rst_note_active", 32'(note_active), 0);
    check("rst_beat", 32'(beat), 0);
    check("rst_song_done", 32'(song_done), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    @(posedge clk);
    #2;
    reset     = 1'b1;
    strobe_en = 1'b1;
    @(negedge clk);

    // Normal playback with first-note latency
    press(0);
    check("lat_fetch_new_note", 32'(new_note), 0);
    check("lat_fetch_addr", 32'(rom_addr), 0);
    @(negedge clk);
    check("lat_load_new_note", 32'(new_note), 0);
    @(negedge clk);
    check("lat_new_note", 32'(new_note), 1);
    check("lat_note_active", 32'(note_active), 1);
    check("norm_note0", 32'(note), 10);
    run_note(0, st, bt, ok);
    check("norm_strobes0", 32'(st), 8);
    check("norm_beats0", 32'(bt), 2);
    wait_new_note(ok);
    check("norm_nn1", 32'(ok), 1);
    check("norm_note1", 32'(note), 20);
    run_note(0, st, bt, ok);
    check("norm_strobes1", 32'(st), 4);
    wait_done(ok);
    check("norm_done", 32'(ok), 1);
    @(negedge clk);
    exp_song = 1;
    check("norm_play", 32'(play), 0);
    check("norm_song", 32'(current_song), 1);

    // Pause mid-note, then abort with next
    press(0);
    wait_new_note(ok);
    run_note(3, st, bt, ok);
    check("pause_pre_strobes", 32'(st), 3);
    press(0);
    check("pause_play", 32'(play), 0);
    check("pause_active", 32'(note_active), 0);
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      if (beat || note_active || new_note) viol++;
      @(negedge clk);
    end
    check("pause_quiet", 32'(viol), 0);
    press(0);
    check("resume_play", 32'(play), 1);
    check("resume_note", 32'(note), 10);
    run_note(0, st, bt, ok);
    check("resume_strobes", 32'(st), 5);
    check("resume_beats", 32'(bt), 2);
    press(1);
    exp_song = 2;
    check("abort_play", 32'(play), 0);
    check("abort_active", 32'(note_active), 0);
    check("abort_song", 32'(current_song), 2);
    check("abort_addr", 32'(rom_addr), 32'(2 * N_ENT));

    // Fast-forward on song 2
    play_song_check("ff", 1'b1);

    // Reverse on song 3
    press(0);
    wait_new_note(ok);
    run_note(0, st, bt, ok);
    wait_new_note(ok);
    check("rw_note1", 32'(note), 20);
    rw_switch = 1'b1;
    run_note(0, st, bt, ok);
    check("rw_strobes1", 32'(st), 4);
    wait_new_note(ok);
    check("rw_nn_replay", 32'(ok), 1);
    check("rw_note_replay", 32'(note), 10);
    run_note(0, st, bt, ok);
    check("rw_strobes_replay", 32'(st), 8);
    wait_done(ok);
    check("rw_done", 32'(ok), 1);
    @(negedge clk);
    rw_switch = 1'b0;
    exp_song = 0;
    check("rw_song", 32'(current_song), 0);
    check("rw_play", 32'(play), 0);

    // Song buttons
    press(2);
    check("prev_wrap", 32'(current_song), 3);
    press(1);
    check("next_wrap", 32'(current_song), 0);
    check("next_play", 32'(play), 0);
    press(1);
    press(3);
    exp_song = 2;
    check("both_next_wins", 32'(current_song), 2);

    // Randomized songs, one filling every index
    for (int it = 0; it < 6; it++) begin
      load_random(exp_song, it == 2);
      play_song_check("rnd", 1'($urandom_range(0, 1)));
    end

    // Repeat switch at song end
    set_ent(exp_song, 0, 33, 1);
    set_ent(exp_song, 1, 5, 0);
    repeat_switch = 1'b1;
    press(0);
    wait_new_note(ok);
    check("rep_note", 32'(note), 33);
    run_note(0, st, bt, ok);
    check("rep_strobes", 32'(st), 4);
    wait_done(ok);
    check("rep_done", 32'(ok), 1);
    @(negedge clk);
`ifdef SEQ_REPEAT_EN
    check("rep_play", 32'(play), 1);
    check("rep_song", 32'(current_song), 32'(exp_song));
    wait_new_note(ok);
    check("rep_restart", 32'(ok), 1);
    check("rep_restart_note", 32'(note), 33);
    press(1);
`else
    check("rep_play", 32'(play), 0);
`endif
    exp_song = (exp_song + 1) % NS;
    check("rep_song_after", 32'(current_song), 32'(exp_song));
    repeat_switch = 1'b0;

    // Asynchronous reset mid-note
    set_ent(exp_song, 0, 44, 3);
    set_ent(exp_song, 1, 5, 0);
    press(0);
    wait_new_note(ok);
    run_note(2, st, bt, ok);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_note", 32'(note), 0);
    check("arst_active", 32'(note_active), 0);
    check("arst_play", 32'(play), 0);
    check("arst_song", 32'(current_song), 0);
    check("arst_addr", 32'(rom_addr), 0);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    exp_song = 0;
    play_song_check("post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/music_sequencer.md
# music_sequencer

Parametrised next-generation song control block: it merges master control (play/pause, next/previous song), beat generation and song-ROM stepping into one sequencer. The sequencer counts note durations itself and supports fast-forward, reverse stepping and optional song repeat. It sits between the debounced button/switch inputs, an external synchronous song ROM, and the note/chord players. It is clocked by the codec's 48 kHz `generate_next_sample` strobe domain.

## Interface
- `NUM_SONGS`, 4: songs in ROM, ≥2; `SONG_W = $clog2(NUM_SONGS)`.
- `SONG_ADDR_W`, 5: entries per song = 2^SONG_ADDR_W.
- `NOTE_W`, 6: note field width.
- `DUR_W`, 6: duration field width (beats).
- `BEAT_COUNT`, 1000: sample strobes per beat at normal speed, ≥2.
- `BEAT_CNT_W`, 10: beat counter width; must satisfy 2^BEAT_CNT_W ≥ BEAT_COUNT.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `play_button` in 1: one-pulsed; toggles play/pause.
- `next_button` in 1: one-pulsed; stops and advances the song.
- `prev_button` in 1: one-pulsed; stops and goes to the previous song.
- `ff_switch` in 1: level; selects double beat rate.
- `rw_switch` in 1: level; steps the song index backward.
- `repeat_switch` in 1: level; restarts the same song at its end (only with `SEQ_REPEAT_EN`).
- `generate_next_sample` in 1: 48 kHz one-cycle strobe.
- `rom_addr` out SONG_W+SONG_ADDR_W: `{song, idx}`, registered.
- `rom_data` in NOTE_W+DUR_W: `{note, duration}`; valid one cycle after `rom_addr`.
- `note` out NOTE_W: current note.
- `new_note` out 1: one-cycle pulse when `note` is loaded.
- `note_active` out 1: high while a note is sounding.
- `beat` out 1: one-cycle beat pulse.
- `play` out 1: playing flag.
- `current_song` out SONG_W: selected song.
- `song_done` out 1: one-cycle pulse at song end.

## Operation
- **States:** IDLE, FETCH, LOAD, SOUND, PAUSE, END.
- **IDLE** (`play`=0):
  - `play_button` → FETCH, `play`=1.
- **FETCH:** `rom_addr` is already stable. Lasts one cycle → LOAD.
- **LOAD:** samples `rom_data`.
  - Duration field 0 (end marker) → END.
  - Otherwise: `note` and the remaining-beat counter load, the beat counter clears, `new_note` pulses next cycle → SOUND.
- **SOUND** (`note_active`=1):
  - Each `generate_next_sample` increments the beat counter.
  - At terminal count (BEAT_COUNT−1, or (BEAT_COUNT>>1)−1 when `ff_switch`=1) the counter wraps to 0 and `beat` pulses.
  - Each beat decrements the remaining-beat counter. When a beat arrives with remaining=1, the note ends and the index steps: idx+1, or idx−1 if `rw_switch`=1.
  - Index boundaries: forward from 2^SONG_ADDR_W−1 → END. Reverse from 0 → END. Otherwise → FETCH.
  - `play_button` → PAUSE.
- **PAUSE:**
  - `play`=0, `note_active`=0.
  - Beat counter and remaining-beat counter are frozen; `note` is held.
  - `play_button` → SOUND with counters intact.
- **END:** `song_done` pulses, idx←0.
  - With repeat active and `repeat_switch`=1: `play` stays 1 → FETCH.
  - Otherwise: `play`←0, `current_song`←(song+1) mod NUM_SONGS → IDLE.
- **Next/prev buttons** act in any state and take priority over `play_button` and over the END transition:
  - Effect: → IDLE, `play`=0, `note_active`=0, idx=0, beat counter=0.
  - Song change: `next_button` gives +1 mod NUM_SONGS; `prev_button` gives −1 mod NUM_SONGS.
  - Both asserted in the same cycle: `next_button` wins.
- **Switch changes:**
  - `ff_switch` change takes effect at the next compare.
  - If the counter is already ≥ the new terminal count, it wraps on the next strobe and `beat` pulses.
  - `rw_switch` is sampled only at index-step time.

## Timing
- **Reset values:** `play`, `current_song`, `note`, `new_note`, `note_active`, `beat`, `song_done`, `rom_addr` all 0. State = IDLE.
- **`play_button` to first note:**
  - `play_button` at cycle t → FETCH at t+1, LOAD at t+2.
  - `new_note`=1 and `note_active`=1 at t+3.
- **Note length:** exactly duration × beat-period strobes.
- **Inter-note gap:** 2 cycles (FETCH, LOAD), plus the `new_note` cycle. Strobes arriving in FETCH or LOAD are ignored.
- **Output timing:** `beat` is registered and asserts the cycle after the terminal strobe. `song_done` asserts the cycle after LOAD or SOUND exits to END.
- **Reset mid-operation:** asynchronous assertion clears everything immediately. Deassertion resumes in IDLE with song 0.

## Configuration
- **`SEQ_REPEAT_EN` defined:** `repeat_switch` is honoured at END as described above.
- **`SEQ_REPEAT_EN` undefined:**
  - `repeat_switch` is ignored and no repeat logic is built.
  - END always clears `play` and advances the song.

## Test plan
All scenarios use NUM_SONGS=4, BEAT_COUNT=4, with a strobe every 3 cycles.
- **Normal playback:** song 0 ROM = (10,2), (20,1), (x,0); press play.
  - `new_note` with `note`=10; `note_active` for 8 strobes.
  - Then `note`=20 for 4 strobes.
  - Then `song_done` pulse, `play`=0, `current_song`=1.
- **Pause mid-note:** pause after 3 strobes of (10,2), wait 10 strobes, resume.
  - Note ends exactly 5 strobes after resume.
  - No `beat` pulses during PAUSE.
- **Fast-forward:** `ff_switch`=1 on (10,2) → note lasts 4 strobes, with `beat` every 2 strobes.
- **Reverse:** `rw_switch`=1 asserted during entry idx 1 (20,1).
  - Entry 0 (10) replays next.
  - Then END from idx 0, `current_song`=1.
- **Song buttons:**
  - `next_button` with song 3 → `current_song`=0, `play`=0.
  - `next_button` + `prev_button` together from song 1 → 2.
  - `prev_button` from song 0 → 3.
- **Repeat and reset:** with `SEQ_REPEAT_EN` and `repeat_switch`=1, song 0 restarts at idx 0 with `play`=1. `reset` low mid-note clears all outputs within the same cycle.
